// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory responder and its SRAM.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } rsp_state_t;

    // Size 2'b11 yields an empty strobe; the caller flags it as an error.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 4'b0001 << off;
            MEM_H:   return 4'b0011 << off;
            MEM_W:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_H:   return off[0];
            MEM_W:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_sram.sv
// Word-organised SRAM with per-byte write strobes and a registered read port.
module byte_sram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    strb_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// byte-lane steering into a local SRAM, raw aligned word returned on loads.
module dmem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output rsp_state_t  dbg_state
);

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse with no backpressure.

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    rsp_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        resp_err_q, rd_ok_q;

    logic        accept, commit;
    logic        cur_we;
    logic [1:0]  cur_size, off;
    logic [31:0] cur_addr, cur_wdata, offset, lane_data;
    logic        out_of_range, req_bad;
    logic [31:0] sram_rdata;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge itself, so the
    // live request fields are used in IDLE and the latched copy afterwards.
    assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign cur_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

    assign off          = cur_addr[1:0];
    assign offset       = cur_addr - BASE_ADDR;
    assign out_of_range = (cur_addr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));
    assign req_bad      = out_of_range || (cur_size == 2'b11) || is_misaligned(cur_size, off);

    always_comb begin
        lane_data = cur_wdata;
        case (cur_size)
            MEM_B:   lane_data = {4{cur_wdata[7:0]}};
            MEM_H:   lane_data = {2{cur_wdata[15:0]}};
            default: lane_data = cur_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_err_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                resp_err_q <= req_bad;
                rd_ok_q    <= !cur_we && !req_bad;
            end
        end
    end

    byte_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk    (clk),
        .we_i   (commit && !reset && cur_we && !req_bad),
        .strb_i (lane_strobe(cur_size, off)),
        .re_i   (commit && !reset && !cur_we && !req_bad),
        .addr_i (offset[AW+1:2]),
        .wdata_i(lane_data),
        .rdata_o(sram_rdata)
    );

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rd_ok_q ? sram_rdata : 32'd0;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

endmodule
